// File: rtl/branch_predictor.sv
// Bimodal branch direction predictor with an IF->EX prediction pipeline.
// Optional build macro BP_STATS_EN adds branch / misprediction counters.
module branch_predictor #(
  parameter int unsigned IDX_BITS   = 6,
  parameter int unsigned PRED_DELAY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_if,
  input  logic [6:0]  opcode_if,
  input  logic        stall,
  input  logic        flush_pipe,
  output logic        pred_if,
  output logic        pred_ex,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken
`ifdef BP_STATS_EN
  ,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispred
`endif
);

  localparam int unsigned ENTRIES   = 1 << IDX_BITS;
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;
  localparam logic [1:0]  CTR_RESET = 2'b01;

  logic [1:0]            ctr_q [ENTRIES];
  logic [1:0]            ctr_d [ENTRIES];
  logic [PRED_DELAY-1:0] pipe_q;
  logic [PRED_DELAY-1:0] pipe_d;

  logic [IDX_BITS-1:0]   lkp_idx;
  logic [IDX_BITS-1:0]   upd_idx;

  assign lkp_idx = pc_if[IDX_BITS+1:2];
  assign upd_idx = upd_pc[IDX_BITS+1:2];

  // PC bits outside the index field are deliberately ignored (aliasing).
  logic unused_pc_bits;
  assign unused_pc_bits = ^{pc_if[31:IDX_BITS+2], pc_if[1:0],
                            upd_pc[31:IDX_BITS+2], upd_pc[1:0]};

  // Lookup: only conditional branches are predicted; no update bypass.
  always_comb begin
    pred_if = 1'b0;
    if (opcode_if == OP_BRANCH) begin
      pred_if = ctr_q[lkp_idx][1];
    end
  end

  assign pred_ex = pipe_q[PRED_DELAY-1];

  // Saturating counter training from resolved EX outcomes.
  always_comb begin
    ctr_d = ctr_q;
    if (upd_valid) begin
      if (upd_taken) begin
        if (ctr_q[upd_idx] != 2'b11) begin
          ctr_d[upd_idx] = ctr_q[upd_idx] + 2'd1;
        end
      end else begin
        if (ctr_q[upd_idx] != 2'b00) begin
          ctr_d[upd_idx] = ctr_q[upd_idx] - 2'd1;
        end
      end
    end
  end

  // Prediction shift register: flush beats stall, stall holds, else shift.
  always_comb begin
    pipe_d = pipe_q;
    if (flush_pipe) begin
      pipe_d = '0;
    end else if (!stall) begin
      pipe_d[0] = pred_if;
      for (int unsigned i = 1; i < PRED_DELAY; i++) begin
        pipe_d[i] = pipe_q[i-1];
      end
    end
  end

  // State registers for the counter table and the prediction pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        ctr_q[i] <= CTR_RESET;
      end
      pipe_q <= '0;
    end else begin
      ctr_q  <= ctr_d;
      pipe_q <= pipe_d;
    end
  end

`ifdef BP_STATS_EN
  logic [31:0] stat_branches_q, stat_branches_d;
  logic [31:0] stat_mispred_q,  stat_mispred_d;

  // Count resolved branches and those whose carried prediction was wrong.
  always_comb begin
    stat_branches_d = stat_branches_q;
    stat_mispred_d  = stat_mispred_q;
    if (upd_valid) begin
      stat_branches_d = stat_branches_q + 32'd1;
      if (upd_taken != pred_ex) begin
        stat_mispred_d = stat_mispred_q + 32'd1;
      end
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches_q <= '0;
      stat_mispred_q  <= '0;
    end else begin
      stat_branches_q <= stat_branches_d;
      stat_mispred_q  <= stat_mispred_d;
    end
  end

  assign stat_branches = stat_branches_q;
  assign stat_mispred  = stat_mispred_q;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: vector table for lookups and
// training, scoreboard queue for the delayed pred_ex, plus async reset cases.
module tb_branch_predictor;

  localparam int unsigned IDX_BITS   = 6;
  localparam int unsigned PRED_DELAY = 2;
  localparam logic [6:0]  BR   = 7'b1100011;
  localparam logic [6:0]  JAL  = 7'b1101111;
  localparam logic [6:0]  JALR = 7'b1100111;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_if;
  logic [6:0]  opcode_if;
  logic        stall;
  logic        flush_pipe;
  logic        pred_if;
  logic        pred_ex;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
`ifdef BP_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispred;
`endif

  always #5 clk = ~clk;

  branch_predictor #(.IDX_BITS(IDX_BITS), .PRED_DELAY(PRED_DELAY)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pc_if      (pc_if),
    .opcode_if  (opcode_if),
    .stall      (stall),
    .flush_pipe (flush_pipe),
    .pred_if    (pred_if),
    .pred_ex    (pred_ex),
    .upd_valid  (upd_valid),
    .upd_pc     (upd_pc),
    .upd_taken  (upd_taken)
`ifdef BP_STATS_EN
    ,
    .stat_branches (stat_branches),
    .stat_mispred  (stat_mispred)
`endif
  );

  typedef struct {
    logic [31:0] pc;
    logic [6:0]  opc;
    logic        stl;
    logic        fl;
    logic        uv;
    logic [31:0] upc;
    logic        ut;
    logic        exp_if;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  logic        m_pipe [PRED_DELAY];
  logic [31:0] m_br;
  logic [31:0] m_mis;
  logic        exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < PRED_DELAY; i++) m_pipe[i] = 1'b0;
    m_br  = '0;
    m_mis = '0;
    exp_q.delete();
  endtask

  task automatic idle_inputs();
    pc_if = 32'h0; opcode_if = 7'h0; stall = 1'b0; flush_pipe = 1'b0;
    upd_valid = 1'b0; upd_pc = 32'h0; upd_taken = 1'b0;
  endtask

  // One cycle: drive, check pred_if, advance model, clock, check pred_ex.
  task automatic apply(input vec_t v, input string name);
    logic e;
    pc_if = v.pc; opcode_if = v.opc; stall = v.stl; flush_pipe = v.fl;
    upd_valid = v.uv; upd_pc = v.upc; upd_taken = v.ut;
    #1;
    check({name, " pred_if"}, 32'(pred_if), 32'(v.exp_if));
    if (v.uv) begin
      m_br = m_br + 32'd1;
      if (v.ut != m_pipe[PRED_DELAY-1]) m_mis = m_mis + 32'd1;
    end
    if (v.fl) begin
      for (int i = 0; i < PRED_DELAY; i++) m_pipe[i] = 1'b0;
    end else if (!v.stl) begin
      for (int i = PRED_DELAY - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
      m_pipe[0] = v.exp_if;
    end
    exp_q.push_back(m_pipe[PRED_DELAY-1]);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_tests++; n_fail++;
      $display("FAIL %s pred_ex: scoreboard empty", name);
    end else begin
      e = exp_q.pop_front();
      check({name, " pred_ex"}, 32'(pred_ex), 32'(e));
    end
`ifdef BP_STATS_EN
    check({name, " stat_branches"}, stat_branches, m_br);
    check({name, " stat_mispred"},  stat_mispred,  m_mis);
`endif
  endtask

  vec_t vecs [$];

  function automatic vec_t mk(input logic [31:0] pc, input logic [6:0] opc,
                              input logic stl, input logic fl, input logic uv,
                              input logic [31:0] upc, input logic ut,
                              input logic exp_if);
    vec_t v;
    v.pc = pc; v.opc = opc; v.stl = stl; v.fl = fl; v.uv = uv;
    v.upc = upc; v.ut = ut; v.exp_if = exp_if;
    return v;
  endfunction

  initial begin
    idle_inputs();
    model_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    pc_if = 32'h100; opcode_if = BR;
    #1;
    check("reset pred_ex", 32'(pred_ex), 32'd0);
    check("reset pred_if", 32'(pred_if), 32'd0);
`ifdef BP_STATS_EN
    check("reset stat_branches", stat_branches, 32'd0);
    check("reset stat_mispred",  stat_mispred,  32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Counter state for index 0 noted in comments (starts at 01).
    vecs.push_back(mk(32'h100, BR,   0, 0, 0, 32'h0,   0, 0)); // 01
    vecs.push_back(mk(32'h100, JAL,  0, 0, 0, 32'h0,   0, 0));
    vecs.push_back(mk(32'h100, BR,   0, 0, 1, 32'h100, 1, 0)); // same-index: old 01 -> 10
    vecs.push_back(mk(32'h100, BR,   0, 0, 1, 32'h100, 1, 1)); // 10 -> 11
    vecs.push_back(mk(32'h100, BR,   0, 0, 1, 32'h100, 1, 1)); // 11 stays
    vecs.push_back(mk(32'h100, JAL,  0, 0, 0, 32'h0,   0, 0)); // jump never predicted
    vecs.push_back(mk(32'h100, BR,   0, 0, 1, 32'h100, 0, 1)); // 11 -> 10
    vecs.push_back(mk(32'h100, BR,   0, 0, 1, 32'h100, 0, 1)); // 10 -> 01
    vecs.push_back(mk(32'h100, BR,   0, 0, 0, 32'h0,   0, 0));
    vecs.push_back(mk(32'h100, BR,   0, 0, 1, 32'h100, 0, 0)); // 01 -> 00
    vecs.push_back(mk(32'h100, BR,   0, 0, 1, 32'h100, 0, 0)); // 00 stays
    vecs.push_back(mk(32'h100, BR,   0, 0, 1, 32'h100, 1, 0)); // 00 -> 01
    vecs.push_back(mk(32'h100, BR,   0, 0, 1, 32'h100, 1, 0)); // 01 -> 10
    vecs.push_back(mk(32'h200, BR,   0, 0, 0, 32'h0,   0, 1)); // alias of 0x100
    vecs.push_back(mk(32'h104, BR,   0, 0, 0, 32'h0,   0, 0)); // neighbour entry
    vecs.push_back(mk(32'h103, BR,   0, 0, 0, 32'h0,   0, 1)); // low bits ignored
    vecs.push_back(mk(32'h10000100, BR, 0, 0, 0, 32'h0, 0, 1)); // high bits ignored
    vecs.push_back(mk(32'h100, BR,   0, 0, 0, 32'h0,   0, 1)); // delay: load 1
    vecs.push_back(mk(32'h104, BR,   1, 0, 0, 32'h0,   0, 0)); // stall adds a cycle
    vecs.push_back(mk(32'h104, BR,   0, 0, 0, 32'h0,   0, 0));
    vecs.push_back(mk(32'h104, BR,   0, 0, 0, 32'h0,   0, 0));
    vecs.push_back(mk(32'h100, BR,   0, 0, 0, 32'h0,   0, 1)); // flush: load 1
    vecs.push_back(mk(32'h104, BR,   1, 1, 0, 32'h0,   0, 0)); // flush beats stall
    vecs.push_back(mk(32'h104, BR,   0, 0, 0, 32'h0,   0, 0));
    vecs.push_back(mk(32'h104, BR,   0, 0, 0, 32'h0,   0, 0));
    vecs.push_back(mk(32'h100, JALR, 0, 0, 0, 32'h0,   0, 0));
    vecs.push_back(mk(32'h100, 7'h0, 0, 0, 0, 32'h0,   0, 0));
    vecs.push_back(mk(32'h104, BR,   1, 1, 1, 32'h104, 1, 0)); // update despite stall/flush: 01->10
    vecs.push_back(mk(32'h104, BR,   0, 0, 0, 32'h0,   0, 1));
    vecs.push_back(mk(32'h100, BR,   0, 0, 0, 32'h0,   0, 1)); // fill pipe with 1s
    vecs.push_back(mk(32'h100, BR,   0, 0, 1, 32'h104, 0, 1)); // pred_ex=1 vs taken=0

    foreach (vecs[i]) apply(vecs[i], $sformatf("row%0d", i));

    // Mid-cycle async reset with pipeline full of 1s and an update pending.
    upd_valid = 1'b1; upd_pc = 32'h100; upd_taken = 1'b1;
    pc_if = 32'h100; opcode_if = BR;
    #3 rst_n = 1'b0;
    #1;
    check("async rst pred_ex", 32'(pred_ex), 32'd0);
    check("async rst pred_if", 32'(pred_if), 32'd0);
`ifdef BP_STATS_EN
    check("async rst stat_branches", stat_branches, 32'd0);
    check("async rst stat_mispred",  stat_mispred,  32'd0);
`endif
    idle_inputs();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    apply(mk(32'h100, BR, 0, 0, 0, 32'h0,   0, 0), "post_rst0");
    apply(mk(32'h104, BR, 0, 0, 0, 32'h0,   0, 0), "post_rst1");
    apply(mk(32'h100, BR, 0, 0, 1, 32'h100, 1, 0), "post_rst2"); // mispredict counted
    apply(mk(32'h100, BR, 0, 0, 0, 32'h0,   0, 1), "post_rst3");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
